// File: rtl/video_timing_gen.sv
// Raster source: programmable hs/porch/active line timing, vblank/active frame structure, test patterns.
// Latency: hs_o rises on the 2nd rising edge after reg_en is presented in IDLE (sampling edge + output register); pattern shares de_o's register stage.
// Backpressure: none; free-running source, configuration is shadowed and only changes at frame boundaries.
module video_timing_gen #(
  parameter int PIXEL_WIDTH = 12,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reg_en,
  input  logic [CNT_WIDTH-1:0]   reg_hs_width,
  input  logic [CNT_WIDTH-1:0]   reg_hbp,
  input  logic [CNT_WIDTH-1:0]   reg_hfp,
  input  logic [CNT_WIDTH-1:0]   reg_pix_count,
  input  logic [CNT_WIDTH-1:0]   reg_line_count,
  input  logic [CNT_WIDTH-1:0]   reg_vblank,
  input  logic [3:0]             reg_sparse,
  input  logic [1:0]             reg_mode,
  input  logic [PIXEL_WIDTH-1:0] reg_color,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [CNT_WIDTH:0]   LINE_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_HSYNC, S_HBP, S_ACTIVE, S_HFP} state_t;

  state_t state, state_nxt;

  // Shadow copies of the configuration; zero-means-one clamps are applied on load.
  logic [CNT_WIDTH-1:0]   sh_hs_width, sh_hbp, sh_hfp, sh_pix_count, sh_line_count, sh_vblank;
  logic [3:0]             sh_sparse;
  logic [1:0]             sh_mode;
  logic [PIXEL_WIDTH-1:0] sh_color;

  // phase_cnt times HSYNC/HBP/HFP; pix_cnt and sparse_cnt together time ACTIVE.
  logic [CNT_WIDTH-1:0] phase_cnt, pix_cnt;
  logic [3:0]           sparse_cnt;
  // One extra bit so vblank+line_count never wraps.
  logic [CNT_WIDTH:0]   line_idx, last_line, y_idx;

  logic latch_cfg, cfg_load, line_end, frame_end, in_blank;
  logic hs_nxt, vs_nxt, de_nxt;
  logic [PIXEL_WIDTH-1:0] do_nxt;
  logic unused_hi;

  function automatic logic [CNT_WIDTH-1:0] at_least_one(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  assign last_line = {1'b0, sh_vblank} + {1'b0, sh_line_count} - LINE_ONE;
  assign in_blank  = line_idx < {1'b0, sh_vblank};
  assign y_idx     = line_idx - {1'b0, sh_vblank};
  assign cfg_load  = (state == S_IDLE) || latch_cfg;
  assign unused_hi = ^{pix_cnt[CNT_WIDTH-1:PIXEL_WIDTH], y_idx[CNT_WIDTH:PIXEL_WIDTH]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: per-phase terminal counts, then end-of-line / end-of-frame decision.
  always_comb begin
    state_nxt = state;
    latch_cfg = 1'b0;
    line_end  = 1'b0;
    case (state)
      S_IDLE: begin
        if (reg_en) begin
          state_nxt = S_HSYNC;
          latch_cfg = 1'b1;
        end
      end
      S_HSYNC: begin
        if (phase_cnt == sh_hs_width - CNT_ONE)
          state_nxt = (sh_hbp != '0) ? S_HBP : S_ACTIVE;
      end
      S_HBP: begin
        if (phase_cnt == sh_hbp - CNT_ONE) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if ((pix_cnt == sh_pix_count - CNT_ONE) && (sparse_cnt == sh_sparse)) begin
          if (sh_hfp != '0) state_nxt = S_HFP;
          else              line_end  = 1'b1;
        end
      end
      S_HFP: begin
        if (phase_cnt == sh_hfp - CNT_ONE) line_end = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    frame_end = line_end && (line_idx == last_line);
    if (line_end) begin
      if (!frame_end) begin
        state_nxt = S_HSYNC;
      end else if (reg_en) begin
        state_nxt = S_HSYNC;
        latch_cfg = 1'b1;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  // Configuration shadow: tracks the inputs while idle, refreshed only at frame boundaries otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_hs_width   <= '0;
      sh_hbp        <= '0;
      sh_hfp        <= '0;
      sh_pix_count  <= '0;
      sh_line_count <= '0;
      sh_vblank     <= '0;
      sh_sparse     <= '0;
      sh_mode       <= '0;
      sh_color      <= '0;
    end else if (cfg_load) begin
      sh_hs_width   <= at_least_one(reg_hs_width);
      sh_hbp        <= reg_hbp;
      sh_hfp        <= reg_hfp;
      sh_pix_count  <= at_least_one(reg_pix_count);
      sh_line_count <= at_least_one(reg_line_count);
      sh_vblank     <= at_least_one(reg_vblank);
      sh_sparse     <= reg_sparse;
      sh_mode       <= reg_mode;
      sh_color      <= reg_color;
    end
  end

  // Timing counters: phase counter restarts on every state change, pixel/sparse pair steps through ACTIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_cnt  <= '0;
      pix_cnt    <= '0;
      sparse_cnt <= '0;
      line_idx   <= '0;
    end else begin
      if (state_nxt != state)
        phase_cnt <= '0;
      else if ((state == S_HSYNC) || (state == S_HBP) || (state == S_HFP))
        phase_cnt <= phase_cnt + CNT_ONE;

      if ((state != S_ACTIVE) || (state_nxt != S_ACTIVE)) begin
        pix_cnt    <= '0;
        sparse_cnt <= '0;
      end else if (sparse_cnt == sh_sparse) begin
        sparse_cnt <= '0;
        pix_cnt    <= pix_cnt + CNT_ONE;
      end else begin
        sparse_cnt <= sparse_cnt + 4'd1;
      end

      if (latch_cfg || frame_end || (state == S_IDLE))
        line_idx <= '0;
      else if (line_end)
        line_idx <= line_idx + LINE_ONE;
    end
  end

  // Output decode: syncs, pixel-valid on the first clock of each sparse slot, pattern from (x, y).
  always_comb begin
    hs_nxt = (state == S_HSYNC);
    vs_nxt = (state != S_IDLE) && in_blank;
    de_nxt = (state == S_ACTIVE) && (sparse_cnt == 4'd0) && !in_blank;
    case (sh_mode)
      2'd0:    do_nxt = pix_cnt[PIXEL_WIDTH-1:0];
      2'd1:    do_nxt = y_idx[PIXEL_WIDTH-1:0];
      2'd2:    do_nxt = (pix_cnt[3] ^ y_idx[3]) ? sh_color : '0;
      default: do_nxt = sh_color;
    endcase
    if (!de_nxt) do_nxt = '0;
  end

  // Output register: every output leaves the block from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
    end else begin
      do_o <= do_nxt;
      de_o <= de_nxt;
      hs_o <= hs_nxt;
      vs_o <= vs_nxt;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed and random frames against a per-clock raster model.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_en;
  logic [15:0] reg_hs_width, reg_hbp, reg_hfp, reg_pix_count, reg_line_count, reg_vblank;
  logic [3:0]  reg_sparse;
  logic [1:0]  reg_mode;
  logic [11:0] reg_color;
  logic [11:0] do_o;
  logic        de_o, hs_o, vs_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        en;
    logic [15:0] hs, hbp, hfp, pix, lines, vbl;
    logic [3:0]  sp;
    logic [1:0]  mode;
    logic [11:0] color;
  } cfg_t;

  typedef struct packed {
    logic        hs, vs, de;
    logic [11:0] dat;
  } smp_t;

  smp_t exp_q[$];

  video_timing_gen #(.PIXEL_WIDTH(12), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .reg_en(reg_en),
    .reg_hs_width(reg_hs_width), .reg_hbp(reg_hbp), .reg_hfp(reg_hfp),
    .reg_pix_count(reg_pix_count), .reg_line_count(reg_line_count), .reg_vblank(reg_vblank),
    .reg_sparse(reg_sparse), .reg_mode(reg_mode), .reg_color(reg_color),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish within budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0h, expected %0h", tag, idx, obs, expv);
    end
  endtask

  function automatic cfg_t mk_cfg(input int en, input int hs, input int hbp, input int hfp, input int pix,
                                  input int lines, input int vbl, input int sp, input int mode, input int color);
    cfg_t c;
    c.en = 1'(en);       c.hs = 16'(hs);       c.hbp = 16'(hbp); c.hfp = 16'(hfp);
    c.pix = 16'(pix);    c.lines = 16'(lines); c.vbl = 16'(vbl); c.sp = 4'(sp);
    c.mode = 2'(mode);   c.color = 12'(color);
    return c;
  endfunction

  function automatic cfg_t rand_cfg(input int en);
    return mk_cfg(en, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
                  $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 4095));
  endfunction

  task automatic drive_cfg(input cfg_t c);
    reg_en = c.en;          reg_hs_width = c.hs;     reg_hbp = c.hbp;   reg_hfp = c.hfp;
    reg_pix_count = c.pix;  reg_line_count = c.lines; reg_vblank = c.vbl;
    reg_sparse = c.sp;      reg_mode = c.mode;       reg_color = c.color;
  endtask

  function automatic smp_t mk(input logic hs, input logic vs, input logic de, input logic [11:0] dat);
    smp_t s;
    s.hs = hs; s.vs = vs; s.de = de; s.dat = dat;
    return s;
  endfunction

  // Pattern value of pixel (x, y); checker parity expressed via 8x8 cell coordinates.
  function automatic logic [11:0] pattern(input cfg_t c, input int x, input int y);
    case (c.mode)
      2'd0:    return x[11:0];
      2'd1:    return y[11:0];
      2'd2:    return ((((x / 8) + (y / 8)) % 2) == 1) ? c.color : 12'h000;
      default: return c.color;
    endcase
  endfunction

  // Expected output of one whole frame, one entry per clock, starting at the hs_o rise of line 0.
  task automatic build_frame(input cfg_t c);
    int hw, pc, lc, vb;
    logic blank, de;
    hw = (c.hs == 0) ? 1 : int'(c.hs);
    pc = (c.pix == 0) ? 1 : int'(c.pix);
    lc = (c.lines == 0) ? 1 : int'(c.lines);
    vb = (c.vbl == 0) ? 1 : int'(c.vbl);
    exp_q.delete();
    for (int l = 0; l < vb + lc; l++) begin
      blank = (l < vb);
      for (int k = 0; k < hw; k++) exp_q.push_back(mk(1'b1, blank, 1'b0, 12'h000));
      for (int k = 0; k < int'(c.hbp); k++) exp_q.push_back(mk(1'b0, blank, 1'b0, 12'h000));
      for (int x = 0; x < pc; x++) begin
        for (int s = 0; s <= int'(c.sp); s++) begin
          de = (s == 0) && !blank;
          exp_q.push_back(mk(1'b0, blank, de, de ? pattern(c, x, l - vb) : 12'h000));
        end
      end
      for (int k = 0; k < int'(c.hfp); k++) exp_q.push_back(mk(1'b0, blank, 1'b0, 12'h000));
    end
  endtask

  // Compare up to stop_at clocks of the expected frame; at clock poke_at drive the next configuration.
  task automatic run_frame(input int poke_at, input cfg_t poke, input int stop_at,
                           output int vs_cnt, output int de_cnt);
    int n;
    smp_t e;
    n = exp_q.size();
    if (stop_at < n) n = stop_at;
    vs_cnt = 0;
    de_cnt = 0;
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      if (i == poke_at) drive_cfg(poke);
      check("hs_o", i, 32'(hs_o), 32'(e.hs));
      check("vs_o", i, 32'(vs_o), 32'(e.vs));
      check("de_o", i, 32'(de_o), 32'(e.de));
      check("do_o", i, 32'(do_o), 32'(e.dat));
      if (vs_o) vs_cnt++;
      if (de_o) de_cnt++;
      @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_hs"}, i, 32'(hs_o), 32'd0);
      check({tag, "_vs"}, i, 32'(vs_o), 32'd0);
      check({tag, "_de"}, i, 32'(de_o), 32'd0);
      check({tag, "_do"}, i, 32'(do_o), 32'd0);
      @(negedge clk);
    end
  endtask

  // reg_en was driven just before this call: hs_o must stay low one clock, then rise with vs_o.
  task automatic align_start(input string tag);
    @(negedge clk);
    check({tag, "_lat_hs0"}, 0, 32'(hs_o), 32'd0);
    @(negedge clk);
    check({tag, "_lat_hs1"}, 0, 32'(hs_o), 32'd1);
    check({tag, "_lat_vs1"}, 0, 32'(vs_o), 32'd1);
  endtask

  initial begin
    cfg_t c, nxt, basic;
    int vsn, den, p;
    basic = mk_cfg(1, 2, 3, 1, 4, 2, 1, 0, 0, 0);
    rst_n = 1'b0;
    c = basic;
    c.en = 1'b0;
    drive_cfg(c);
    repeat (3) @(negedge clk);
    check_quiet("reset", 1);
    rst_n = 1'b1;
    check_quiet("idle_dis", 3);

    // Basic raster; pix_count changes to 8 during line 1 and must only affect the next frame.
    drive_cfg(basic);
    align_start("start");
    build_frame(basic);
    nxt = basic;
    nxt.pix = 16'd8;
    run_frame(15, nxt, 1 << 30, vsn, den);
    check("basic_vs_clocks", 0, 32'(vsn), 32'd10);
    check("basic_de_count", 0, 32'(den), 32'd8);

    c = nxt;
    build_frame(c);
    nxt = c;
    nxt.pix = 16'd4;
    nxt.sp = 4'd2;
    run_frame(5, nxt, 1 << 30, vsn, den);
    check("pix8_de_count", 0, 32'(den), 32'd16);

    // Sparse cadence, then all-zero timing registers.
    c = nxt;
    build_frame(c);
    nxt = mk_cfg(1, 0, 0, 0, 0, 0, 0, 0, 3, 12'h5A5);
    run_frame(7, nxt, 1 << 30, vsn, den);
    check("sparse_de_count", 0, 32'(den), 32'd8);
    check("sparse_vs_clocks", 0, 32'(vsn), 32'd18);

    c = nxt;
    build_frame(c);
    nxt = mk_cfg(1, 1, 0, 0, 16, 16, 1, 0, 2, 12'hABC);
    run_frame(1, nxt, 1 << 30, vsn, den);
    check("zero_de_count", 0, 32'(den), 32'd1);
    check("zero_vs_clocks", 0, 32'(vsn), 32'd2);

    // Checker and vertical ramp patterns.
    c = nxt;
    build_frame(c);
    nxt = mk_cfg(1, 1, 1, 1, 4, 4, 1, 0, 1, 0);
    run_frame(20, nxt, 1 << 30, vsn, den);
    check("checker_de_count", 0, 32'(den), 32'd256);

    c = nxt;
    build_frame(c);
    nxt = rand_cfg(1);
    run_frame(10, nxt, 1 << 30, vsn, den);

    // Random frames; the last poke clears reg_en so the generator must finish the frame and idle.
    for (int r = 0; r < 6; r++) begin
      c = nxt;
      build_frame(c);
      p = exp_q.size() / 3;
      nxt = rand_cfg((r < 5) ? 1 : 0);
      run_frame(p, nxt, 1 << 30, vsn, den);
    end
    check_quiet("after_disable", 5);

    // Restart, then synchronous reset in the middle of line 1.
    drive_cfg(basic);
    align_start("restart");
    build_frame(basic);
    run_frame(-1, basic, 13, vsn, den);
    rst_n = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid", 1);
    rst_n = 1'b1;
    align_start("post_rst");
    build_frame(basic);
    nxt = basic;
    nxt.en = 1'b0;
    run_frame(5, nxt, 1 << 30, vsn, den);
    check_quiet("final_idle", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
